snow64_icache_line_fill: RTL and testbench

SNOW64_ICACHE_LINE_FILL -- requirements
Module: snow64_icache_line_fill

---
 rtl/snow64_icache_line_fill_if.sv | 26 ++
 rtl/snow64_icache_line_fill.sv | 108 ++++++++++
 tb/tb_snow64_icache_line_fill.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/snow64_icache_line_fill_if.sv
// Bundle of the line-fill request, memory beat and completed-line signals.
// slave is the fill engine's view; master is the cache/memory side.
interface snow64_icache_line_fill_if #(
    parameter int WIDTH__LINE = 256,
    parameter int WIDTH__BEAT = 64
);
    logic                   in_req;
    logic [63:0]            in_req_addr;
    logic                   out_valid;
    logic [WIDTH__LINE-1:0] out_data;
    logic                   out_busy;
    logic                   out_mem_req;
    logic [63:0]            out_mem_addr;
    logic                   in_mem_valid;
    logic [WIDTH__BEAT-1:0] in_mem_data;

    modport slave (
        input  in_req, in_req_addr, in_mem_valid, in_mem_data,
        output out_valid, out_data, out_busy, out_mem_req, out_mem_addr
    );

    modport master (
        output in_req, in_req_addr, in_mem_valid, in_mem_data,
        input  out_valid, out_data, out_busy, out_mem_req, out_mem_addr
    );
endinterface

// File: rtl/snow64_icache_line_fill.sv
// Instruction cache line fill: fetches one line as BEATS sequential memory
// beats and presents the assembled line with a one-cycle completion pulse.
module snow64_icache_line_fill #(
    parameter int WIDTH__LINE = 256,
    parameter int WIDTH__BEAT = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    snow64_icache_line_fill_if.slave      bus
);
    localparam int BEATS      = WIDTH__LINE / WIDTH__BEAT;
    localparam int CNT_W      = $clog2(BEATS);
    localparam int LINE_BYTES = WIDTH__LINE / 8;
    localparam int BEAT_SHIFT = $clog2(WIDTH__BEAT / 8);
    localparam logic [63:0]      BASE_MASK = ~(64'(LINE_BYTES) - 64'd1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic {StIdle, StFill} state_t;

    state_t                             state_reg, state_next;
    logic [CNT_W-1:0]                   cnt_reg, cnt_next;
    logic [63:0]                        base_reg, base_next;
    logic [63:0]                        mem_addr_reg, mem_addr_next;
    logic                               mem_req_reg, mem_req_next;
    logic                               valid_reg, valid_next;
    logic [BEATS-1:0][WIDTH__BEAT-1:0]  line_reg, line_next;
    logic [WIDTH__LINE-1:0]             data_reg, data_next;
    logic [BEATS-1:0][WIDTH__BEAT-1:0]  line_merged;
    logic                               beat_accept;

    assign beat_accept = (state_reg == StFill) && mem_req_reg && bus.in_mem_valid;

    // Line buffer with the incoming beat dropped into its slot; only copied
    // to out_data once the final beat lands, so partial lines never escape.
    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_slot
            assign line_merged[gi] = (beat_accept && (cnt_reg == CNT_W'(gi)))
                                     ? bus.in_mem_data : line_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        base_next     = base_reg;
        mem_req_next  = mem_req_reg;
        mem_addr_next = mem_addr_reg;
        valid_next    = 1'b0;
        line_next     = line_reg;
        data_next     = data_reg;
        case (state_reg)
            StIdle: begin
                if (bus.in_req) begin
                    base_next     = bus.in_req_addr & BASE_MASK;
                    mem_addr_next = bus.in_req_addr & BASE_MASK;
                    cnt_next      = '0;
                    mem_req_next  = 1'b1;
                    state_next    = StFill;
                end
            end
            StFill: begin
                if (beat_accept) begin
                    line_next = line_merged;
                    if (cnt_reg == LAST_BEAT) begin
                        mem_req_next = 1'b0;
                        valid_next   = 1'b1;
                        data_next    = line_merged;
                        cnt_next     = '0;
                        state_next   = StIdle;
                    end else begin
                        cnt_next      = cnt_reg + 1'b1;
                        mem_addr_next = base_reg + ((64'(cnt_reg) + 64'd1) << BEAT_SHIFT);
                    end
                end
            end
            default: state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= StIdle;
            cnt_reg      <= '0;
            base_reg     <= '0;
            mem_addr_reg <= '0;
            mem_req_reg  <= 1'b0;
            valid_reg    <= 1'b0;
            line_reg     <= '0;
            data_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            base_reg     <= base_next;
            mem_addr_reg <= mem_addr_next;
            mem_req_reg  <= mem_req_next;
            valid_reg    <= valid_next;
            line_reg     <= line_next;
            data_reg     <= data_next;
        end
    end

    assign bus.out_valid    = valid_reg;
    assign bus.out_data     = data_reg;
    assign bus.out_busy     = (state_reg == StFill);
    assign bus.out_mem_req  = mem_req_reg;
    assign bus.out_mem_addr = mem_addr_reg;
endmodule

// File: tb/tb_snow64_icache_line_fill.sv
// Directed bench for the line-fill engine: table of fills plus hand-written
// reset, stray-input and back-to-back sequences.
module tb_snow64_icache_line_fill;
    logic clk;
    logic rst;

    snow64_icache_line_fill_if #(.WIDTH__LINE(256), .WIDTH__BEAT(64)) bus ();

    snow64_icache_line_fill #(.WIDTH__LINE(256), .WIDTH__BEAT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]       addr;
        int                waits;
        logic [3:0][63:0]  beats;
        logic [63:0]       base;
        logic [255:0]      line;
    } vec_t;

    vec_t         tbl [4];
    int           checks;
    int           failures;
    logic [255:0] last_line;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"},    256'(bus.out_valid),    256'd0);
        chk({tag, "_data"},     bus.out_data,           256'd0);
        chk({tag, "_busy"},     256'(bus.out_busy),     256'd0);
        chk({tag, "_mem_req"},  256'(bus.out_mem_req),  256'd0);
        chk({tag, "_mem_addr"}, 256'(bus.out_mem_addr), 256'd0);
    endtask

    // One full fill from table entry idx. pre_acc: request already accepted
    // by the previous call. stray: hold in_req at another address mid-fill.
    // chain: raise the next request on the out_valid cycle.
    task automatic run_fill(input int idx, input bit stray, input bit pre_acc,
                            input bit chain, input logic [63:0] chain_addr);
        vec_t v;
        int   cyc;
        v = tbl[idx];
        if (!pre_acc) begin
            bus.in_req      = 1'b1;
            bus.in_req_addr = v.addr;
            tick();
        end
        bus.in_req      = stray;
        bus.in_req_addr = 64'h9000;
        cyc = 1;
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < v.waits; w++) begin
                chk("wait_mem_req",  256'(bus.out_mem_req),  256'd1);
                chk("wait_mem_addr", 256'(bus.out_mem_addr), 256'(v.base + 64'(k * 8)));
                chk("wait_busy",     256'(bus.out_busy),     256'd1);
                chk("wait_data",     bus.out_data,           last_line);
                tick();
                cyc++;
            end
            chk("beat_mem_req",  256'(bus.out_mem_req),  256'd1);
            chk("beat_mem_addr", 256'(bus.out_mem_addr), 256'(v.base + 64'(k * 8)));
            chk("beat_valid",    256'(bus.out_valid),    256'd0);
            chk("beat_data",     bus.out_data,           last_line);
            bus.in_mem_valid = 1'b1;
            bus.in_mem_data  = v.beats[k];
            if (k == 3) bus.in_req = 1'b0;
            tick();
            cyc++;
            bus.in_mem_valid = 1'b0;
            bus.in_mem_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        end
        chk("done_valid",   256'(bus.out_valid),   256'd1);
        chk("done_data",    bus.out_data,          v.line);
        chk("done_busy",    256'(bus.out_busy),    256'd0);
        chk("done_mem_req", 256'(bus.out_mem_req), 256'd0);
        chk("done_latency", 256'(cyc),             256'(1 + 4 * (v.waits + 1)));
        last_line = v.line;
        if (chain) begin
            bus.in_req      = 1'b1;
            bus.in_req_addr = chain_addr;
        end
        tick();
        bus.in_req = 1'b0;
        chk("post_valid", 256'(bus.out_valid), 256'd0);
        chk("post_data",  bus.out_data,        last_line);
        chk("post_mem_req", 256'(bus.out_mem_req), chain ? 256'd1 : 256'd0);
        chk("post_busy",    256'(bus.out_busy),    chain ? 256'd1 : 256'd0);
        $display("fill idx=%0d addr=%h waits=%0d latency=%0d line=%h",
                 idx, v.addr, v.waits, cyc, bus.out_data);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        last_line = '0;

        tbl[0].addr  = 64'h1234;
        tbl[0].waits = 0;
        tbl[0].beats = {64'hD0D0D0D0D0D0D0D0, 64'hC0C0C0C0C0C0C0C0,
                        64'hB0B0B0B0B0B0B0B0, 64'hA0A0A0A0A0A0A0A0};
        tbl[0].base  = 64'h1220;
        tbl[0].line  = 256'hD0D0D0D0D0D0D0D0_C0C0C0C0C0C0C0C0_B0B0B0B0B0B0B0B0_A0A0A0A0A0A0A0A0;

        tbl[1].addr  = 64'h1234;
        tbl[1].waits = 3;
        tbl[1].beats = {64'h4444444444444444, 64'h3333333333333333,
                        64'h2222222222222222, 64'h1111111111111111};
        tbl[1].base  = 64'h1220;
        tbl[1].line  = 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;

        tbl[2].addr  = 64'h40;
        tbl[2].waits = 0;
        tbl[2].beats = {64'h4, 64'h3, 64'h2, 64'h1};
        tbl[2].base  = 64'h40;
        tbl[2].line  = 256'h0000000000000004_0000000000000003_0000000000000002_0000000000000001;

        tbl[3].addr  = 64'hFFFF_FFFF_FFFF_FFFF;
        tbl[3].waits = 1;
        tbl[3].beats = {64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFFFFF};
        tbl[3].base  = 64'hFFFF_FFFF_FFFF_FFE0;
        tbl[3].line  = 256'h0000000000000000_FFFFFFFFFFFFFFFF_0000000000000000_FFFFFFFFFFFFFFFF;

        rst              = 1'b1;
        bus.in_req       = 1'b0;
        bus.in_req_addr  = '0;
        bus.in_mem_valid = 1'b0;
        bus.in_mem_data  = '0;
        tick();
        tick();
        chk_zero_outputs("reset");
        rst = 1'b0;
        tick();
        chk_zero_outputs("idle");

        // Zero-wait and wait-state fills from the table.
        run_fill(0, 1'b0, 1'b0, 1'b0, 64'h0);
        run_fill(1, 1'b0, 1'b0, 1'b0, 64'h0);

        // Stray beats while idle must not move anything.
        for (int i = 0; i < 3; i++) begin
            bus.in_mem_valid = 1'b1;
            bus.in_mem_data  = 64'h5A5A_5A5A_5A5A_5A5A;
            tick();
            chk("stray_busy",    256'(bus.out_busy),    256'd0);
            chk("stray_mem_req", 256'(bus.out_mem_req), 256'd0);
            chk("stray_valid",   256'(bus.out_valid),   256'd0);
            chk("stray_data",    bus.out_data,          last_line);
        end
        bus.in_mem_valid = 1'b0;
        $display("stray beats in idle applied");

        // Fill with a competing request held high during the fill.
        run_fill(0, 1'b1, 1'b0, 1'b0, 64'h0);

        // Back-to-back: second request on the out_valid cycle.
        run_fill(2, 1'b0, 1'b0, 1'b1, tbl[3].addr);
        run_fill(3, 1'b0, 1'b1, 1'b0, 64'h0);

        // Reset mid-fill after two beats.
        bus.in_req      = 1'b1;
        bus.in_req_addr = 64'h1234;
        tick();
        bus.in_req       = 1'b0;
        bus.in_mem_valid = 1'b1;
        bus.in_mem_data  = 64'h5555_5555_5555_5555;
        tick();
        bus.in_mem_data  = 64'h6666_6666_6666_6666;
        tick();
        bus.in_mem_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero_outputs("abort");
        for (int i = 0; i < 4; i++) begin
            bus.in_mem_valid = 1'b1;
            bus.in_mem_data  = 64'h7777_7777_7777_7777;
            tick();
            chk("late_valid",   256'(bus.out_valid),   256'd0);
            chk("late_busy",    256'(bus.out_busy),    256'd0);
            chk("late_mem_req", 256'(bus.out_mem_req), 256'd0);
            chk("late_data",    bus.out_data,          256'd0);
        end
        bus.in_mem_valid = 1'b0;
        $display("reset mid-fill applied, late beats ignored");
        last_line = '0;
        run_fill(2, 1'b0, 1'b0, 1'b0, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
